// File: rtl/ka_seq_sched_48bit_if.sv
// Bundle between the Karatsuba scheduler, its requester and the shared
// half-width carry-less multiply core.
interface ka_seq_sched_48bit_if #(
  parameter int N = 48
);
  localparam int H = N / 2;

  logic           start;
  logic [N-1:0]   a_in;
  logic [N-1:0]   b_in;
  logic           busy;
  logic           done;
  logic [2*N-2:0] result;
  logic           mul_req;
  logic [H-1:0]   mul_op_a;
  logic [H-1:0]   mul_op_b;
  logic           mul_ack;
  logic [2*H-2:0] mul_prod;

  modport master (
    output start, a_in, b_in, mul_ack, mul_prod,
    input  busy, done, result, mul_req, mul_op_a, mul_op_b
  );

  modport slave (
    input  start, a_in, b_in, mul_ack, mul_prod,
    output busy, done, result, mul_req, mul_op_a, mul_op_b
  );
endinterface

// File: rtl/ka_seq_sched_48bit.sv
// Sequential one-level Karatsuba scheduler: a GF(2)[x] N x N product built
// from three H x H products obtained from a shared core.
module ka_seq_sched_48bit #(
  parameter int N = 48
) (
  input logic                 clk,
  input logic                 rst_n,
  ka_seq_sched_48bit_if.slave bus
);
  localparam int H = N / 2;

  typedef enum logic [2:0] {
    IDLE, REQ_LO, REQ_MID, REQ_HI, COMBINE, DONE
  } state_t;

  state_t         state, state_nx;
  logic [N-1:0]   a_q, b_q;
  logic [2*H-2:0] p0, p1, p2;
  logic [2*N-2:0] result_q;
  logic [2*N-2:0] comb;
  logic [2*H-2:0] mid;
  logic [H-1:0]   op_a, op_b;
  logic           req;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (bus.start)   state_nx = REQ_LO;
      REQ_LO:  if (bus.mul_ack) state_nx = REQ_MID;
      REQ_MID: if (bus.mul_ack) state_nx = REQ_HI;
      REQ_HI:  if (bus.mul_ack) state_nx = COMBINE;
      COMBINE: state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Operands come straight from the latched inputs, so they cannot move while a request waits.
  always_comb begin
    req  = 1'b0;
    op_a = '0;
    op_b = '0;
    case (state)
      REQ_LO: begin
        req  = 1'b1;
        op_a = a_q[H-1:0];
        op_b = b_q[H-1:0];
      end
      REQ_MID: begin
        req  = 1'b1;
        op_a = a_q[H-1:0] ^ a_q[N-1:H];
        op_b = b_q[H-1:0] ^ b_q[N-1:H];
      end
      REQ_HI: begin
        req  = 1'b1;
        op_a = a_q[N-1:H];
        op_b = b_q[N-1:H];
      end
      default: begin
        req  = 1'b0;
        op_a = '0;
        op_b = '0;
      end
    endcase
  end

  // Over GF(2) the Karatsuba middle term is P0^P1^P2; subtraction is XOR.
  always_comb begin
    mid            = p0 ^ p1 ^ p2;
    comb           = '0;
    comb[2*H-2:0]  = comb[2*H-2:0]   ^ p0;
    comb[3*H-2:H]  = comb[3*H-2:H]   ^ mid;
    comb[4*H-2:2*H] = comb[4*H-2:2*H] ^ p2;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q      <= '0;
      b_q      <= '0;
      p0       <= '0;
      p1       <= '0;
      p2       <= '0;
      result_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            a_q <= bus.a_in;
            b_q <= bus.b_in;
          end
        end
        REQ_LO:  if (bus.mul_ack) p0 <= bus.mul_prod;
        REQ_MID: if (bus.mul_ack) p1 <= bus.mul_prod;
        REQ_HI:  if (bus.mul_ack) p2 <= bus.mul_prod;
        COMBINE: result_q <= comb;
        default: ;
      endcase
    end
  end

  assign bus.busy     = (state != IDLE);
  assign bus.done     = (state == DONE);
  assign bus.mul_req  = req;
  assign bus.mul_op_a = op_a;
  assign bus.mul_op_b = op_b;
  assign bus.result   = result_q;
endmodule

// File: tb/tb_ka_seq_sched_48bit.sv
// Bench for ka_seq_sched_48bit: a behavioural multiply core with variable
// ack latency, and a plain shift-and-XOR carry-less product as reference.
module tb_ka_seq_sched_48bit;
  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  ka_seq_sched_48bit_if #(.N(48)) bus ();

  ka_seq_sched_48bit #(.N(48)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [46:0] clmul24(input logic [23:0] x, input logic [23:0] y);
    logic [46:0] r;
    r = '0;
    for (int i = 0; i < 24; i++)
      if (y[i]) r = r ^ (47'(x) << i);
    return r;
  endfunction

  function automatic logic [94:0] clmul48(input logic [47:0] x, input logic [47:0] y);
    logic [94:0] r;
    r = '0;
    for (int i = 0; i < 48; i++)
      if (y[i]) r = r ^ (95'(x) << i);
    return r;
  endfunction

  // Latency is counted as rising edges after the start-sampling edge up to the
  // edge that samples done=1. fixed_delay < 0 picks a random 0..4 wait per request.
  task automatic run_op(input logic [47:0] a, input logic [47:0] b,
                        input int fixed_delay, input bit poke,
                        output logic [94:0] res, output int cycles, output int waits,
                        output bit ops_ok, output bit busy_ok, output bit idle_ok);
    logic [23:0] exp_a[3];
    logic [23:0] exp_b[3];
    int idx, wcnt, dly;
    exp_a[0] = a[23:0];            exp_b[0] = b[23:0];
    exp_a[1] = a[23:0] ^ a[47:24]; exp_b[1] = b[23:0] ^ b[47:24];
    exp_a[2] = a[47:24];           exp_b[2] = b[47:24];
    ops_ok = 1'b1; busy_ok = 1'b1; idle_ok = 1'b1;
    res = '0; cycles = -1; waits = 0; idx = 0; wcnt = 0;
    dly = (fixed_delay < 0) ? int'($urandom_range(4, 0)) : fixed_delay;
    @(negedge clk);
    bus.a_in = a; bus.b_in = b; bus.start = 1'b1; bus.mul_ack = 1'b0;
    @(posedge clk);
    @(negedge clk);
    bus.start = poke;
    bus.a_in  = 48'({$urandom(), $urandom()});
    bus.b_in  = 48'({$urandom(), $urandom()});
    for (int e = 0; e < 200; e++) begin
      if (bus.done) begin
        res    = bus.result;
        cycles = e + 1;
        break;
      end
      if (!bus.busy) busy_ok = 1'b0;
      if (bus.mul_req) begin
        if (idx > 2) ops_ok = 1'b0;
        else if (bus.mul_op_a !== exp_a[idx] || bus.mul_op_b !== exp_b[idx]) ops_ok = 1'b0;
        if (wcnt == dly) begin
          bus.mul_ack  = 1'b1;
          bus.mul_prod = (idx < 3) ? clmul24(exp_a[idx], exp_b[idx]) : '0;
          idx++;
          wcnt = 0;
          dly  = (fixed_delay < 0) ? int'($urandom_range(4, 0)) : fixed_delay;
        end else begin
          bus.mul_ack = 1'b0;
          wcnt++;
          waits++;
        end
      end else begin
        if (bus.mul_op_a !== 24'd0 || bus.mul_op_b !== 24'd0) ops_ok = 1'b0;
        bus.mul_ack  = 1'b1;
        bus.mul_prod = 47'({$urandom(), $urandom()});
      end
      @(posedge clk);
      @(negedge clk);
    end
    bus.mul_ack = 1'b0;
    if (idx != 3) ops_ok = 1'b0;
    @(posedge clk);
    @(negedge clk);
    if (bus.busy || bus.done) idle_ok = 1'b0;
    bus.start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    if (bus.busy) idle_ok = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.start = 1'b0; bus.a_in = '0; bus.b_in = '0;
    bus.mul_ack = 1'b0; bus.mul_prod = '0;
    #1;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %b expected 0", bus.done); end
    checks++; if (bus.mul_req !== 1'b0) begin errors++; $display("[TB] FAIL reset_mul_req: got %b expected 0", bus.mul_req); end
    checks++; if (bus.result !== 95'd0) begin errors++; $display("[TB] FAIL reset_result: got %h expected 0", bus.result); end
    checks++; if (bus.mul_op_a !== 24'd0 || bus.mul_op_b !== 24'd0) begin errors++; $display("[TB] FAIL reset_ops: got %h/%h expected 0/0", bus.mul_op_a, bus.mul_op_b); end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL idle_no_start: got busy=%b expected 0", bus.busy); end
  endtask

  task automatic test_unit();
    logic [94:0] res; int cyc, w; bit ok_ops, ok_busy, ok_idle;
    run_op(48'd1, 48'd1, 0, 1'b0, res, cyc, w, ok_ops, ok_busy, ok_idle);
    checks++; if (res !== 95'd1) begin errors++; $display("[TB] FAIL unit_result: got %h expected 1", res); end
    checks++; if (cyc !== 5) begin errors++; $display("[TB] FAIL unit_latency: got %0d expected 5", cyc); end
    checks++; if (ok_busy !== 1'b1) begin errors++; $display("[TB] FAIL unit_busy: got %b expected 1", ok_busy); end
    checks++; if (ok_ops !== 1'b1) begin errors++; $display("[TB] FAIL unit_ops: got %b expected 1", ok_ops); end
    checks++; if (ok_idle !== 1'b1) begin errors++; $display("[TB] FAIL unit_done_pulse: got %b expected 1", ok_idle); end
  endtask

  task automatic test_top_bit();
    logic [94:0] res; int cyc, w; bit ok_ops, ok_busy, ok_idle;
    logic [94:0] exp;
    exp = '0; exp[94] = 1'b1;
    run_op(48'h800000000000, 48'h800000000000, 0, 1'b0, res, cyc, w, ok_ops, ok_busy, ok_idle);
    checks++; if (res !== exp) begin errors++; $display("[TB] FAIL top_bit_result: got %h expected %h", res, exp); end
    checks++; if (ok_ops !== 1'b1 || ok_busy !== 1'b1 || ok_idle !== 1'b1 || cyc !== 5)
      begin errors++; $display("[TB] FAIL top_bit_flow: got ops=%b busy=%b idle=%b cyc=%0d expected 1 1 1 5", ok_ops, ok_busy, ok_idle, cyc); end
  endtask

  task automatic test_cancel();
    logic [94:0] res; int cyc, w; bit ok_ops, ok_busy, ok_idle;
    logic [94:0] exp;
    exp = '0; exp[48] = 1'b1; exp[0] = 1'b1;
    run_op(48'h000001000001, 48'h000001000001, 0, 1'b0, res, cyc, w, ok_ops, ok_busy, ok_idle);
    checks++; if (res !== exp) begin errors++; $display("[TB] FAIL cancel_result: got %h expected %h", res, exp); end
    checks++; if (ok_ops !== 1'b1) begin errors++; $display("[TB] FAIL cancel_ops: got %b expected 1", ok_ops); end
    checks++; if (cyc !== 5 || ok_busy !== 1'b1 || ok_idle !== 1'b1)
      begin errors++; $display("[TB] FAIL cancel_flow: got cyc=%0d busy=%b idle=%b expected 5 1 1", cyc, ok_busy, ok_idle); end
  endtask

  task automatic test_back_to_back_delay();
    logic [94:0] res; int cyc, w; bit ok_ops, ok_busy, ok_idle;
    logic [47:0] a, b;
    a = 48'h123456789abc; b = 48'hfedcba987654;
    run_op(a, b, 3, 1'b1, res, cyc, w, ok_ops, ok_busy, ok_idle);
    checks++; if (cyc !== 14) begin errors++; $display("[TB] FAIL delay_latency: got %0d expected 14", cyc); end
    checks++; if (ok_ops !== 1'b1) begin errors++; $display("[TB] FAIL delay_ops_stable: got %b expected 1", ok_ops); end
    checks++; if (ok_idle !== 1'b1) begin errors++; $display("[TB] FAIL delay_start_ignored: got %b expected 1", ok_idle); end
    checks++; if (res !== clmul48(a, b)) begin errors++; $display("[TB] FAIL delay_result: got %h expected %h", res, clmul48(a, b)); end
    checks++; if (ok_busy !== 1'b1 || w !== 9) begin errors++; $display("[TB] FAIL delay_busy_waits: got busy=%b waits=%0d expected 1 9", ok_busy, w); end
  endtask

  task automatic test_reset_mid();
    logic [94:0] res; int cyc, w; bit ok_ops, ok_busy, ok_idle;
    logic [47:0] a, b;
    @(negedge clk);
    bus.a_in = 48'hdeadbeef1234; bus.b_in = 48'h0f0f0f0f0f0f; bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0; bus.mul_ack = 1'b1; bus.mul_prod = 47'h1;
    @(posedge clk);
    @(negedge clk);
    bus.mul_ack = 1'b0;
    checks++; if (bus.mul_req !== 1'b1 || bus.result === 95'd0)
      begin errors++; $display("[TB] FAIL mid_setup: got req=%b result=%h expected 1 and nonzero", bus.mul_req, bus.result); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (bus.busy !== 1'b0 || bus.mul_req !== 1'b0 || bus.done !== 1'b0)
      begin errors++; $display("[TB] FAIL mid_reset_ctrl: got busy=%b req=%b done=%b expected 0 0 0", bus.busy, bus.mul_req, bus.done); end
    checks++; if (bus.result !== 95'd0 || bus.mul_op_a !== 24'd0)
      begin errors++; $display("[TB] FAIL mid_reset_data: got result=%h op_a=%h expected 0 0", bus.result, bus.mul_op_a); end
    @(negedge clk);
    rst_n = 1'b1;
    a = 48'hcafef00d5a5a; b = 48'h13579bdf2468;
    run_op(a, b, -1, 1'b0, res, cyc, w, ok_ops, ok_busy, ok_idle);
    checks++; if (res !== clmul48(a, b) || ok_ops !== 1'b1 || ok_busy !== 1'b1 || ok_idle !== 1'b1 || cyc !== 5 + w)
      begin errors++; $display("[TB] FAIL mid_recover: got %h cyc=%0d expected %h cyc=%0d", res, cyc, clmul48(a, b), 5 + w); end
  endtask

  task automatic test_random();
    logic [94:0] res; int cyc, w; bit ok_ops, ok_busy, ok_idle;
    logic [47:0] a, b;
    for (int n = 0; n < 1000; n++) begin
      a = 48'({$urandom(), $urandom()});
      b = 48'({$urandom(), $urandom()});
      run_op(a, b, -1, n[0], res, cyc, w, ok_ops, ok_busy, ok_idle);
      checks++; if (res !== clmul48(a, b))
        begin errors++; $display("[TB] FAIL rand_result #%0d: a=%h b=%h got %h expected %h", n, a, b, res, clmul48(a, b)); end
      checks++; if (cyc !== 5 + w || ok_ops !== 1'b1 || ok_busy !== 1'b1 || ok_idle !== 1'b1)
        begin errors++; $display("[TB] FAIL rand_flow #%0d: got cyc=%0d ops=%b busy=%b idle=%b expected cyc=%0d 1 1 1", n, cyc, ok_ops, ok_busy, ok_idle, 5 + w); end
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_unit();
    test_top_bit();
    test_cancel();
    test_back_to_back_delay();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
